// File: rtl/sha256_pkg.sv
// SHA-256 constants, state encoding and the FIPS 180-4 logical functions
// shared by the round datapath and the compression engine.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working state A..H packed A-first,
// advanced by one round constant and one schedule word.
module sha256_round (
  input  logic [255:0] state_cur,
  input  logic [31:0]  k_t,
  input  logic [31:0]  w_t,
  output logic [255:0] state_nxt
);
  import sha256_pkg::*;

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  always_comb begin
    {a, b, c, d, e, f, g, h} = state_cur;
    t1 = h + big_sigma1(e) + ch(e, f, g) + k_t + w_t;
    t2 = big_sigma0(a) + maj(a, b, c);
    state_nxt = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

// File: rtl/sha256_compress_engine.sv
// Multi-cycle SHA-256 compression: ROUNDS_PER_CYCLE chained rounds per
// clock with a sliding 16-word message schedule window.
module sha256_compress_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [255:0] in_hash,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_hash
);
  import sha256_pkg::*;

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_r
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t       state_q;
  logic [6:0]   round_cnt;
  logic [255:0] h_q;
  logic [255:0] work;
  logic [255:0] rnd_out;
  logic [255:0] digest;
  word_t        win     [0:15];
  word_t        win_nxt [0:15];
  word_t        ext     [0:15+R];

  for (genvar i = 0; i < R; i++) begin : g_rnd
    logic [255:0] s_in;
    logic [255:0] s_out;
    logic [5:0]   t_idx;
    if (i == 0) begin : g_head
      assign s_in = work;
    end else begin : g_link
      assign s_in = g_rnd[i-1].s_out;
    end
    assign t_idx = round_cnt[5:0] + 6'(i);
    sha256_round u_round (
      .state_cur (s_in),
      .k_t       (K[t_idx]),
      .w_t       (win[i]),
      .state_nxt (s_out)
    );
  end

  assign rnd_out = g_rnd[R-1].s_out;

  // Later new words depend on earlier new words of the same cycle.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j]
                + small_sigma0(ext[1+j]) + ext[j];
    end
    for (int i = 0; i < 16; i++) win_nxt[i] = ext[i+R];
  end

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) begin
      digest[255-32*i -: 32] = h_q[255-32*i -: 32]
                             + work[255-32*i -: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_hash  <= '0;
      round_cnt <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (in_first) begin
              h_q  <= {IV[0], IV[1], IV[2], IV[3],
                       IV[4], IV[5], IV[6], IV[7]};
              work <= {IV[0], IV[1], IV[2], IV[3],
                       IV[4], IV[5], IV[6], IV[7]};
            end else begin
              h_q  <= in_hash;
              work <= in_hash;
            end
            for (int i = 0; i < 16; i++) begin
              win[i] <= in_block[511-32*i -: 32];
            end
            round_cnt <= '0;
            in_ready  <= 1'b0;
            state_q   <= S_ROUND;
          end
        end
        S_ROUND: begin
          work      <= rnd_out;
          win       <= win_nxt;
          round_cnt <= round_cnt + 7'(R);
          if (round_cnt == 7'(64 - R)) state_q <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid) begin
            out_hash  <= digest;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
